dff8_access_ctrl: RTL and testbench
===================================

# dff8_access_ctrl

Round-robin access controller that shares one 8-bit falling-edge data register (D, CLK, synchro_clr, Q) between NREQ requesters. Each requester asks for either a load of its data word or a synchronous clear. The controller arbitrates, drives the register's D and synchro_clr inputs for exactly one commit cycle, and returns a one-cycle acknowledge. It sits between the requesting blocks and the external register instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- CLK  in  1  clock; all state updates on falling edge
- synchro_clr  in  1  synchronous active-high reset
- req  in  NREQ  per-requester load request, level
- clr_req  in  NREQ  per-requester clear request, level
- wdata  in  NREQ*WIDTH  flattened load data; requester i at bits [i*WIDTH +: WIDTH]
- reg_q  in  WIDTH  Q fed back from the shared register
- reg_d  out  WIDTH  to register D
- reg_clr  out  1  to register synchro_clr
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot completion pulse, registered
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states:
  - IDLE: if any bit of (req | clr_req) is set, pick a winner, latch its index, op and data, set gnt, and go to COMMIT. Otherwise stay.
  - COMMIT: drive the latched op for one cycle, then go to ACK.
  - ACK: pulse ack[winner], clear gnt, then go to IDLE.
- Winner selection: rotating priority. Search starts at index ptr+1 mod NREQ; the first set bit of (req | clr_req) wins. At accept, ptr is set to the winner.
- Op resolution: if clr_req[w] is set, the op is CLEAR, even when req[w] is also set. Otherwise the op is LOAD with data wdata[w], latched at accept.
- reg_d is combinational:
  - in COMMIT with LOAD: reg_d = latched data.
  - in all other cases: reg_d = reg_q, so the register holds its value.
- reg_clr is combinational: reg_clr = synchro_clr | (state==COMMIT & op==CLEAR).
- Requester protocol:
  - hold req or clr_req until ack is seen; deassert in the ack cycle.
  - a request still high on the edge after ack is treated as a new request.
- Early drop: if a requester drops its request after accept, the transaction still completes and ack is still issued. Inputs are sampled only in IDLE.
- Reset state:
  - state = IDLE; ptr = NREQ-1, so requester 0 has first priority.
  - gnt = 0, ack = 0, busy = 0, latched data = 0.
  - the register is cleared through reg_clr.
- Reset mid-transaction: the transaction is aborted and no ack is issued. The register is cleared and no partial load occurs.

## Timing
- The accept edge is k (IDLE→COMMIT). From edge k:
  - gnt is high during cycles k..k+2.
  - reg_d and reg_clr carry the op during cycle k..k+1.
  - the register captures at edge k+1.
  - ack is high during cycle k+1..k+2.
  - the FSM is back in IDLE after edge k+2.
- Throughput: one transaction per 3 cycles. A requester that is continuously requesting waits at most 3*NREQ cycles.
- No combinational path from req, clr_req or wdata to any output. reg_d depends combinationally on reg_q only.
- LOAD of an arbitrary value (including 0x00) is a full write. CLEAR forces 0.

## Structure
- Shared package holds:
  - the state enum {IDLE, COMMIT, ACK}, 2-bit encoding;
  - the op enum {OP_LOAD, OP_CLEAR};
  - default constants NREQ=4, WIDTH=8.
- One sub-module, rr_pick: combinational rotating-priority picker. Inputs are a request vector and ptr; outputs are a one-hot winner and its index, plus a valid flag.
- The register itself is instantiated outside, next to this controller.

## Test plan
- Single load: reset, then req[0]=1 with wdata[0]=0xA5 → gnt=0001 at the next edge; Q=0xA5 after the following edge; ack=0001 for one cycle; busy back to 0 after 3 cycles.
- Round robin: all four req high with data 0x11, 0x22, 0x33, 0x44 → Q sequence 0x11, 0x22, 0x33, 0x44, acks 0,1,2,3, exactly 3 cycles apart.
- Clear priority: Q=0x5A, then req[2] and clr_req[2] both set with wdata[2]=0xFF → Q=0x00 and ack=0100.
- Fairness after wrap: ptr=3, req[1] and req[3] pending → requester 1 wins first, then requester 3.
- Reset in COMMIT: load 0xC3 accepted, then synchro_clr asserted during COMMIT → Q=0x00, no ack, state IDLE, gnt=0.
- Hold: Q=0x7E and no requests for 20 cycles → reg_d tracks 0x7E, reg_clr=0, Q unchanged.

Source files
------------

// File: rtl/dff8_access_ctrl_pkg.sv
// Shared types and defaults for the round-robin register access controller.
// Pure declarations; no logic, no timing.
package dff8_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_CLEAR = 1'b1
  } op_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // Index width for a requester count; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff8_access_ctrl_rr_pick.sv
// Rotating-priority picker: search starts one past ptr, first set bit wins.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick
  import dff8_access_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]        reqv,
  input  logic [idx_w(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        win_oh,
  output logic [idx_w(NREQ)-1:0] win_idx,
  output logic                   win_vld
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] k;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    k       = '0;
    // i runs 1..NREQ so the current holder of ptr is checked last.
    for (int i = 1; i <= NREQ; i++) begin
      k = IW'((int'(ptr) + i) % NREQ);
      if (!win_vld && reqv[k]) begin
        win_vld   = 1'b1;
        win_idx   = k;
        win_oh[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff8_access_ctrl.sv
// Arbitrates NREQ requesters onto one shared falling-edge register (load or clear).
// Accept -> commit -> ack, 3 cycles per transaction; requesters hold until ack.
module dff8_access_ctrl
  import dff8_access_ctrl_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    CLK,
  input  logic                    synchro_clr,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         clr_req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  input  logic [WIDTH-1:0]        reg_q,
  output logic [WIDTH-1:0]        reg_d,
  output logic                    reg_clr,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    busy
);

  localparam int IW = idx_w(NREQ);

  state_t           state, state_nxt;
  op_t              op, op_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [NREQ-1:0]  gnt_nxt, ack_nxt;

  logic [NREQ-1:0]  pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [NREQ-1:0]  any_req;

  assign any_req = req | clr_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .reqv    (any_req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // Reset drops any in-flight transaction; ptr parks on the last index so requester 0 goes first.
  always_ff @(negedge CLK) begin
    if (synchro_clr) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      op    <= OP_LOAD;
      data  <= '0;
      gnt   <= '0;
      ack   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      op    <= op_nxt;
      data  <= data_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    op_nxt    = op;
    data_nxt  = data;
    gnt_nxt   = gnt;
    ack_nxt   = ack;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = COMMIT;
          ptr_nxt   = pick_idx;
          gnt_nxt   = pick_oh;
          // Clear wins over load when a requester raises both.
          if (clr_req[pick_idx]) begin
            op_nxt   = OP_CLEAR;
            data_nxt = '0;
          end else begin
            op_nxt   = OP_LOAD;
            data_nxt = wdata[pick_idx*WIDTH +: WIDTH];
          end
        end
      end
      COMMIT: begin
        state_nxt = ACK;
        ack_nxt   = gnt;
      end
      ACK: begin
        state_nxt = IDLE;
        ack_nxt   = '0;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        ack_nxt   = '0;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Outside a load commit the register is fed its own Q so it holds.
  assign reg_d   = (state == COMMIT && op == OP_LOAD) ? data : reg_q;
  assign reg_clr = synchro_clr | (state == COMMIT && op == OP_CLEAR);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dff8_access_ctrl.sv
// Bench for dff8_access_ctrl with a behavioural falling-edge register closing the Q loop.
module tb_dff8_access_ctrl;

  logic        CLK;
  logic        synchro_clr;
  logic [3:0]  req, clr_req;
  logic [31:0] wdata;
  logic [7:0]  reg_q, reg_d;
  logic        reg_clr;
  logic [3:0]  gnt, ack;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  dff8_access_ctrl #(.NREQ(4), .WIDTH(8)) dut (
    .CLK         (CLK),
    .synchro_clr (synchro_clr),
    .req         (req),
    .clr_req     (clr_req),
    .wdata       (wdata),
    .reg_q       (reg_q),
    .reg_d       (reg_d),
    .reg_clr     (reg_clr),
    .gnt         (gnt),
    .ack         (ack),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External shared register: falling edge, synchronous clear.
  always_ff @(negedge CLK) reg_q <= reg_clr ? 8'h00 : reg_d;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [3:0]  cq;
    logic [31:0] wd;
    logic [3:0]  e_gnt;
    logic [3:0]  e_ack;
    logic        e_busy;
    logic [7:0]  e_q;
    logic        e_rclr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] cq,
                     input logic [31:0] wd, input logic [3:0] g, input logic [3:0] a,
                     input logic b, input logic [7:0] q, input logic rc);
    vec_t v;
    v.rst = rst; v.rq = rq; v.cq = cq; v.wd = wd;
    v.e_gnt = g; v.e_ack = a; v.e_busy = b; v.e_q = q; v.e_rclr = rc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic wait_gnt(input string name, input logic [3:0] exp);
    int n = 0;
    while (gnt == 4'h0 && n < 8) begin
      tick();
      n++;
    end
    chk(name, {28'h0, gnt}, {28'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    synchro_clr = 1'b1;
    req = '0; clr_req = '0; wdata = '0;

    // rst  req   clr   wdata          gnt   ack   busy q      rclr
    add(1, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h00, 1);
    add(0, 4'h1, 4'h0, 32'hA5,        4'h1, 4'h0, 1, 8'h00, 0);
    add(0, 4'h1, 4'h0, 32'hA5,        4'h1, 4'h1, 1, 8'hA5, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'hA5, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'hA5, 0);
    // round robin from reset priority
    add(1, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h00, 1);
    add(0, 4'hF, 4'h0, 32'h44332211,  4'h1, 4'h0, 1, 8'h00, 0);
    add(0, 4'hF, 4'h0, 32'h44332211,  4'h1, 4'h1, 1, 8'h11, 0);
    add(0, 4'hE, 4'h0, 32'h44332211,  4'h0, 4'h0, 0, 8'h11, 0);
    add(0, 4'hE, 4'h0, 32'h44332211,  4'h2, 4'h0, 1, 8'h11, 0);
    add(0, 4'hE, 4'h0, 32'h44332211,  4'h2, 4'h2, 1, 8'h22, 0);
    add(0, 4'hC, 4'h0, 32'h44332211,  4'h0, 4'h0, 0, 8'h22, 0);
    add(0, 4'hC, 4'h0, 32'h44332211,  4'h4, 4'h0, 1, 8'h22, 0);
    add(0, 4'hC, 4'h0, 32'h44332211,  4'h4, 4'h4, 1, 8'h33, 0);
    add(0, 4'h8, 4'h0, 32'h44332211,  4'h0, 4'h0, 0, 8'h33, 0);
    add(0, 4'h8, 4'h0, 32'h44332211,  4'h8, 4'h0, 1, 8'h33, 0);
    add(0, 4'h8, 4'h0, 32'h44332211,  4'h8, 4'h8, 1, 8'h44, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h44, 0);
    // clear beats load on the same requester
    add(0, 4'h1, 4'h0, 32'h5A,        4'h1, 4'h0, 1, 8'h44, 0);
    add(0, 4'h1, 4'h0, 32'h5A,        4'h1, 4'h1, 1, 8'h5A, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h5A, 0);
    add(0, 4'h4, 4'h4, 32'h00FF0000,  4'h4, 4'h0, 1, 8'h5A, 1);
    add(0, 4'h4, 4'h4, 32'h00FF0000,  4'h4, 4'h4, 1, 8'h00, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h00, 0);
    // reset while a load sits in COMMIT
    add(0, 4'h2, 4'h0, 32'h3C00,      4'h2, 4'h0, 1, 8'h00, 0);
    add(0, 4'h2, 4'h0, 32'h3C00,      4'h2, 4'h2, 1, 8'h3C, 0);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h3C, 0);
    add(0, 4'h1, 4'h0, 32'hC3,        4'h1, 4'h0, 1, 8'h3C, 0);
    add(1, 4'h1, 4'h0, 32'hC3,        4'h0, 4'h0, 0, 8'h00, 1);
    add(0, 4'h0, 4'h0, 32'h0,         4'h0, 4'h0, 0, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      synchro_clr = tbl[i].rst;
      req         = tbl[i].rq;
      clr_req     = tbl[i].cq;
      wdata       = tbl[i].wd;
      tick();
      chk($sformatf("v%0d_gnt", i),  {28'h0, gnt},    {28'h0, tbl[i].e_gnt});
      chk($sformatf("v%0d_ack", i),  {28'h0, ack},    {28'h0, tbl[i].e_ack});
      chk($sformatf("v%0d_busy", i), {31'h0, busy},   {31'h0, tbl[i].e_busy});
      chk($sformatf("v%0d_q", i),    {24'h0, reg_q},  {24'h0, tbl[i].e_q});
      chk($sformatf("v%0d_rclr", i), {31'h0, reg_clr}, {31'h0, tbl[i].e_rclr});
    end

    // Hold: after loading 0x7E, an idle register must feed Q back on D.
    synchro_clr = 1'b0;
    req = 4'h1; wdata = 32'h7E;
    wait_gnt("hold_gnt", 4'h1);
    tick();
    chk("hold_ack", {28'h0, ack}, 32'h1);
    req = 4'h0; wdata = 32'h0;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("hold%0d_d", c),    {24'h0, reg_d},   32'h7E);
      chk($sformatf("hold%0d_rclr", c), {31'h0, reg_clr}, 32'h0);
      chk($sformatf("hold%0d_q", c),    {24'h0, reg_q},   32'h7E);
    end

    // Park ptr on 3 via a real grant, then check the wrap order 1 before 3.
    req = 4'h8; wdata = 32'hA1000000;
    wait_gnt("wrap_g3a", 4'h8);
    tick();
    chk("wrap_ack3a", {28'h0, ack}, 32'h8);
    chk("wrap_q3a", {24'h0, reg_q}, 32'hA1);
    req = 4'h0;
    tick();
    req = 4'hA; wdata = 32'h00009600;
    wait_gnt("wrap_g1", 4'h2);
    tick();
    chk("wrap_ack1", {28'h0, ack}, 32'h2);
    chk("wrap_q1", {24'h0, reg_q}, 32'h96);
    req = 4'h8;
    tick();
    wait_gnt("wrap_g3b", 4'h8);
    tick();
    chk("wrap_ack3b", {28'h0, ack}, 32'h8);
    chk("wrap_q_zero_load", {24'h0, reg_q}, 32'h00);
    req = 4'h0;
    tick();
    chk("wrap_busy", {31'h0, busy}, 32'h0);
    chk("wrap_gnt_idle", {28'h0, gnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
